// File: rtl/cas_key_pkg.sv
// Shared types and constants for the CAS-Lock key loader.
// CAS_KEY_CRC_EN adds the LOCKOUT state used by the CRC-checked build.
package cas_key_pkg;

    localparam int         CAS_KEY_W     = 64;
    localparam logic [7:0] CAS_CRC8_POLY = 8'h07;
    localparam logic [7:0] CAS_CRC8_INIT = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ACTIVE  = 3'd2,
        ST_ERROR   = 3'd3
`ifdef CAS_KEY_CRC_EN
        ,
        ST_LOCKOUT = 3'd4
`endif
    } cas_ld_state_t;

    // One byte through CRC-8, MSB first, no reflection.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] din);
        logic [7:0] c;
        c = crc ^ din;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CAS_CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/cas_crc8.sv
// Byte-serial CRC-8 engine (poly 0x07, init 0x00, no final XOR).
// Instantiated by cas_key_loader only when CAS_KEY_CRC_EN is defined.
module cas_crc8
    import cas_key_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            crc <= CAS_CRC8_INIT;
        end else if (en) begin
            crc <= crc8_byte(crc, din);
        end
    end

endmodule

// File: rtl/cas_key_loader.sv
// Assembles the CAS-Lock unlock key from a byte stream and commits it atomically.
// Define CAS_KEY_CRC_EN to append a CRC-8 beat, count failures and enable LOCKOUT.
module cas_key_loader
    import cas_key_pkg::*;
#(
    parameter int KEY_W    = CAS_KEY_W,
    parameter int CHUNK_W  = 8,
    parameter int MAX_FAIL = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [CHUNK_W-1:0] s_data,
    output logic [KEY_W-1:0]   key_out,
    output logic               key_valid,
    output logic               busy,
    output logic               err
);

    localparam int BEATS = KEY_W / CHUNK_W;
    localparam int CNT_W = $clog2(BEATS + 1);
`ifdef CAS_KEY_CRC_EN
    localparam int XFERS    = BEATS + 1;
    localparam int SHADOW_W = KEY_W;
    localparam int FAIL_W   = $clog2(MAX_FAIL + 1);
`else
    localparam int XFERS    = BEATS;
    // The final beat goes straight to key_out, so it needs no shadow slot.
    localparam int SHADOW_W = KEY_W - CHUNK_W;
`endif
    localparam int SHADOW_BEATS = SHADOW_W / CHUNK_W;

    cas_ld_state_t      state, next_state;
    logic [CNT_W-1:0]   beat_cnt;
    logic [SHADOW_W-1:0] shadow;
    logic [KEY_W-1:0]   commit_key;
    logic               accept;
    logic               final_beat;
    logic               load_req;
    logic               commit;

    assign accept     = s_valid && s_ready;
    assign final_beat = accept && (beat_cnt == CNT_W'(XFERS - 1));

`ifdef CAS_KEY_CRC_EN
    logic [7:0]        crc;
    logic              crc_ok;
    logic              crc_fail;
    logic [FAIL_W-1:0] fail_cnt;
    logic [FAIL_W-1:0] fail_next;
    logic              err_q;

    cas_crc8 u_crc (
        .clk   (clk),
        .rst   (rst),
        .clear (load_req),
        .en    (accept && (beat_cnt < CNT_W'(BEATS))),
        .din   (s_data),
        .crc   (crc)
    );

    assign crc_ok     = (s_data == crc);
    assign fail_next  = fail_cnt + FAIL_W'(1);
    assign commit_key = shadow;
    assign err        = err_q;
`else
    assign commit_key = {s_data, shadow};
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load_req   = 1'b0;
        commit     = 1'b0;
`ifdef CAS_KEY_CRC_EN
        crc_fail   = 1'b0;
`endif
        unique case (state)
            ST_IDLE, ST_ACTIVE, ST_ERROR: begin
                if (start) begin
                    next_state = ST_LOAD;
                    load_req   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (final_beat) begin
`ifdef CAS_KEY_CRC_EN
                    if (crc_ok) begin
                        commit     = 1'b1;
                        next_state = ST_ACTIVE;
                    end else begin
                        crc_fail   = 1'b1;
                        next_state = (fail_next == FAIL_W'(MAX_FAIL)) ? ST_LOCKOUT : ST_ERROR;
                    end
`else
                    commit     = 1'b1;
                    next_state = ST_ACTIVE;
`endif
                end
            end
`ifdef CAS_KEY_CRC_EN
            ST_LOCKOUT: next_state = ST_LOCKOUT;
`endif
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            key_out   <= '0;
            key_valid <= 1'b0;
            shadow    <= '0;
            beat_cnt  <= '0;
`ifdef CAS_KEY_CRC_EN
            err_q     <= 1'b0;
            fail_cnt  <= '0;
`endif
        end else begin
            s_ready <= (next_state == ST_LOAD);
            busy    <= (next_state == ST_LOAD);
            if (load_req) begin
                key_out   <= '0;
                key_valid <= 1'b0;
                shadow    <= '0;
                beat_cnt  <= '0;
`ifdef CAS_KEY_CRC_EN
                err_q     <= 1'b0;
`endif
            end else if (accept) begin
                for (int k = 0; k < SHADOW_BEATS; k++) begin
                    if (beat_cnt == CNT_W'(k)) begin
                        shadow[k*CHUNK_W +: CHUNK_W] <= s_data;
                    end
                end
                beat_cnt <= beat_cnt + CNT_W'(1);
                if (commit) begin
                    key_out   <= commit_key;
                    key_valid <= 1'b1;
`ifdef CAS_KEY_CRC_EN
                    fail_cnt  <= '0;
`endif
                end
`ifdef CAS_KEY_CRC_EN
                if (crc_fail) begin
                    err_q    <= 1'b1;
                    fail_cnt <= fail_next;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_cas_key_loader.sv
// Randomised self-checking bench for cas_key_loader against a queue-based model.
// Covers both builds; CAS_KEY_CRC_EN enables the CRC beat and lockout scenarios.
module tb_cas_key_loader;

    localparam int KEY_W    = 64;
    localparam int CHUNK_W  = 8;
    localparam int BEATS    = KEY_W / CHUNK_W;
    localparam int MAX_FAIL = 3;
`ifdef CAS_KEY_CRC_EN
    localparam int XFERS = BEATS + 1;
`else
    localparam int XFERS = BEATS;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               s_valid = 1'b0;
    logic [CHUNK_W-1:0] s_data = '0;
    logic               s_ready;
    logic [KEY_W-1:0]   key_out;
    logic               key_valid;
    logic               busy;
    logic               err;

    int n_checks = 0;
    int n_errors = 0;

    cas_key_loader #(.KEY_W(KEY_W), .CHUNK_W(CHUNK_W), .MAX_FAIL(MAX_FAIL)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .key_out   (key_out),
        .key_valid (key_valid),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bit-serial CRC-8 step: feed data bits MSB first through the 0x07 LFSR.
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ d[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [7:0] crc_key(input logic [63:0] key);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 0; k < BEATS; k++) c = crc_step(c, key[k*8 +: 8]);
        return c;
    endfunction

    // Behavioural model: a load is a queue of accepted beats; outputs follow from what was received.
    bit          m_loading = 0;
    bit          m_locked  = 0;
    int          m_fails   = 0;
    logic [63:0] m_key     = '0;
    bit          m_valid   = 0;
    bit          m_err     = 0;
    logic [7:0]  q[$];

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_loading = 0; m_locked = 0; m_fails = 0;
                m_key = '0; m_valid = 0; m_err = 0;
                q.delete();
            end else if (!m_loading && !m_locked && start) begin
                m_loading = 1; m_key = '0; m_valid = 0; m_err = 0;
                q.delete();
            end else if (m_loading && s_valid) begin
                q.push_back(s_data);
                if (q.size() == XFERS) begin
                    logic [63:0] k;
                    k = '0;
                    for (int i = 0; i < BEATS; i++) k = k | (64'(q[i]) << (8 * i));
                    m_loading = 0;
`ifdef CAS_KEY_CRC_EN
                    if (crc_key(k) == q[BEATS]) begin
                        m_key = k; m_valid = 1; m_fails = 0;
                    end else begin
                        m_err = 1; m_fails++;
                        if (m_fails == MAX_FAIL) m_locked = 1;
                    end
`else
                    m_key = k; m_valid = 1;
`endif
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("s_ready", 64'(s_ready), 64'(m_loading));
            check("busy", 64'(busy), 64'(m_loading));
            check("key_out", key_out, m_key);
            check("key_valid", 64'(key_valid), 64'(m_valid));
            check("err", 64'(err), 64'(m_err));
        end
    end

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_key(input logic [63:0] key, input int stall, input bit bad_crc, input bit rnd);
        int n;
        for (int k = 0; k < XFERS; k++) begin
            if (k < BEATS) s_data = key[k*8 +: 8];
            else s_data = bad_crc ? ~crc_key(key) : crc_key(key);
            s_valid = 1'b1;
            if (rnd && $urandom_range(0, 7) == 0) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            s_valid = 1'b0;
            n = rnd ? int'($urandom_range(0, 3)) : stall;
            repeat (n) begin
                s_data = 8'($urandom);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [63:0] key;
        logic [7:0]  c;
        logic [71:0] sample;

        sample = 72'h313233343536373839;
        c = 8'h00;
        for (int i = 8; i >= 0; i--) c = crc_step(c, sample[i*8 +: 8]);
        check("crc_ref_123456789", 64'(c), 64'hF4);

        @(negedge clk);
        do_reset();
        check("rst_key_out", key_out, 64'h0);
        check("rst_s_ready", 64'(s_ready), 64'h0);
        check("rst_key_valid", 64'(key_valid), 64'h0);

        // Back-to-back load, latency pinned on the last beat.
        do_start();
        check("load_s_ready", 64'(s_ready), 64'h1);
        key = 64'h0123456789ABCDEF;
        for (int k = 0; k < XFERS; k++) begin
            s_data = (k < BEATS) ? key[k*8 +: 8] : crc_key(key);
            s_valid = 1'b1;
            if (k == XFERS - 1) check("kv_before_last", 64'(key_valid), 64'h0);
            @(negedge clk);
        end
        s_valid = 1'b0;
        check("kv_after_last", 64'(key_valid), 64'h1);
        check("key_b2b", key_out, 64'h0123456789ABCDEF);
        check("model_key_b2b", m_key, 64'h0123456789ABCDEF);

        // Beats in ACTIVE are ignored.
        repeat (4) begin
            s_valid = 1'b1; s_data = 8'($urandom);
            @(negedge clk);
        end
        s_valid = 1'b0;
        check("active_ready", 64'(s_ready), 64'h0);
        check("active_hold", key_out, 64'h0123456789ABCDEF);

        // Restart from ACTIVE clears the key, then a stalled load.
        do_start();
        check("restart_key", key_out, 64'h0);
        check("restart_kv", 64'(key_valid), 64'h0);
        send_key(64'h0123456789ABCDEF, 5, 1'b0, 1'b0);
        check("key_stalled", key_out, 64'h0123456789ABCDEF);
        do_start();
        send_key(64'hFFFFFFFF00000000, 0, 1'b0, 1'b0);
        check("key_reload", key_out, 64'hFFFFFFFF00000000);

        // Reset after four beats discards the partial key.
        do_start();
        for (int k = 0; k < 4; k++) begin
            s_data = 8'h5A ^ 8'(k); s_valid = 1'b1;
            @(negedge clk);
        end
        s_valid = 1'b0;
        do_reset();
        check("midrst_key", key_out, 64'h0);
        check("midrst_busy", 64'(busy), 64'h0);
        check("midrst_kv", 64'(key_valid), 64'h0);
        do_start();
        send_key(64'h1122334455667788, 0, 1'b0, 1'b0);
        check("midrst_new_key", key_out, 64'h1122334455667788);

        // start and s_valid together from IDLE: the beat is not taken.
        do_reset();
        start = 1'b1; s_valid = 1'b1; s_data = 8'hAA;
        @(negedge clk);
        start = 1'b0; s_valid = 1'b0;
        send_key(64'h0F1E2D3C4B5A6978, 0, 1'b0, 1'b0);
        check("start_wins_key", key_out, 64'h0F1E2D3C4B5A6978);

`ifdef CAS_KEY_CRC_EN
        do_reset();
        for (int f = 1; f <= MAX_FAIL; f++) begin
            do_start();
            send_key(64'h0123456789ABCDEF, 0, 1'b1, 1'b0);
            check("crcfail_err", 64'(err), 64'h1);
            check("crcfail_key", key_out, 64'h0);
            check("crcfail_kv", 64'(key_valid), 64'h0);
        end
        do_start();
        repeat (3) @(negedge clk);
        check("lockout_ready", 64'(s_ready), 64'h0);
        check("lockout_busy", 64'(busy), 64'h0);
        check("lockout_err", 64'(err), 64'h1);
        do_reset();
        check("lockout_cleared", 64'(err), 64'h0);
        do_start();
        send_key(64'h0123456789ABCDEF, 0, 1'b0, 1'b0);
        check("after_lockout_key", key_out, 64'h0123456789ABCDEF);
`endif

        // Random loads with random stalls and spurious starts/beats.
        for (int it = 0; it < 20; it++) begin
            key = {$urandom, $urandom};
            do_start();
            send_key(key, 0, 1'b0, 1'b1);
            check("rnd_key", key_out, key);
            repeat ($urandom_range(0, 3)) begin
                s_valid = 1'($urandom); s_data = 8'($urandom);
                @(negedge clk);
            end
            s_valid = 1'b0;
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cas_key_loader.md
# cas_key_loader

Key-provisioning front end for the CAS-Lock protected c1355 netlist. It receives the 64-bit unlock key as byte beats over a valid/ready stream from secure storage and assembles it in a shadow register. It then commits the key atomically to the `keyinput_*` bus of the locked core. Until a full, checked key is committed, the core sees an all-zero key, so its output stays corrupted.

## Interface
Parameters:
- `KEY_W`, default 64: key width; bit i drives the locked core's `keyinput_i`.
- `CHUNK_W`, default 8: bits per stream beat. `KEY_W % CHUNK_W == 0`. `BEATS = KEY_W/CHUNK_W`.
- `MAX_FAIL`, default 3: number of consecutive check failures before permanent lockout. Used only with `CAS_KEY_CRC_EN`.

Ports:
- `clk`, input, 1: sole clock; all state is updated on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: single-cycle request to begin or restart a key load.
- `s_valid`, input, 1: stream beat is valid.
- `s_ready`, output, 1: loader can accept a beat.
- `s_data`, input, `CHUNK_W`: beat payload. Beat k carries key bits `[k*CHUNK_W +: CHUNK_W]`, least-significant beat first.
- `key_out`, output, `KEY_W`: committed key, connected to `keyinput_0..63`.
- `key_valid`, output, 1: `key_out` holds a committed key.
- `busy`, output, 1: a load is in progress.
- `err`, output, 1: the last load failed its check, or the loader is locked out.

## Operation
- States: IDLE, LOAD, ACTIVE, ERROR, and LOCKOUT (LOCKOUT exists only with `CAS_KEY_CRC_EN`).
- Reset: state goes to IDLE. `key_out`=0, `key_valid`=0, `busy`=0, `err`=0, `s_ready`=0. The shadow register, beat counter and fail counter are cleared.
- `start` in IDLE, ACTIVE or ERROR moves the block to LOAD on the next edge:
  - clears `key_out`, `key_valid`, `err`, the shadow register and the beat counter.
- `start` in LOAD is ignored. `start` in LOCKOUT is ignored.
- LOAD:
  - `s_ready`=1 and `busy`=1.
  - A beat is accepted on any edge where `s_valid & s_ready`.
  - Each accepted beat is written to the shadow register at position `beat_cnt`, and `beat_cnt` increments.
  - Stalls (`s_valid`=0) are unlimited.
- End of load without the check feature: the edge that accepts beat `BEATS-1`:
  - writes {final beat, shadow} into `key_out`;
  - sets `key_valid`=1;
  - moves to ACTIVE.
- End of load with the check feature:
  - Beat `BEATS` is a CRC-8 over the data beats in order of arrival (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR).
  - The edge that accepts the CRC beat compares it to the running CRC.
  - Match: commit as above, clear the fail counter, go to ACTIVE.
  - Mismatch: `key_out` stays 0, `err`=1, the fail counter increments. If the new count equals `MAX_FAIL`, go to LOCKOUT; otherwise go to ERROR.
- ACTIVE: `key_out` is held stable and `s_ready`=0. Stream beats are ignored (not accepted).
- LOCKOUT: `err`=1, `key_out`=0, `s_ready`=0. Only `rst` leaves this state.
- `rst` asserted mid-load discards partial data. No shadow bits ever reach `key_out`.

## Timing
- `s_ready` is a registered function of state only. It does not depend combinationally on `s_valid`.
- Load latency: `key_valid` rises in the cycle after the final accepting edge. With back-to-back beats:
  - `start` edge + 8 beat edges: 9 cycles without the check feature;
  - 10 cycles with `CAS_KEY_CRC_EN`.
- `key_out` changes only at the commit edge or the clearing edge. It never shows a partial key.
- `s_valid` and `start` asserted in the same cycle while in IDLE or ACTIVE: `start` wins and the beat is not accepted.

## Configuration
- `CAS_KEY_CRC_EN` defined:
  - a CRC beat is appended (`BEATS+1` transfers);
  - mismatches are counted, and LOCKOUT is reachable;
  - `MAX_FAIL` is honoured.
- `CAS_KEY_CRC_EN` undefined:
  - exactly `BEATS` transfers;
  - no CRC logic, no fail counter, no LOCKOUT state;
  - `err` is tied to 0.

## Structure
- Package `cas_key_pkg` holds:
  - the state enum `cas_ld_state_t`;
  - `CAS_KEY_W=64`;
  - `CAS_CRC8_POLY=8'h07`;
  - the CRC-8 init constant.
- Sub-module `cas_crc8` holds the byte-serial CRC-8 engine: `clk`, `rst`, `clear`, `en`, `din[7:0]`, `crc[7:0]`. It is instantiated only under `CAS_KEY_CRC_EN`.
- The top level holds the FSM, the beat counter (`$clog2(BEATS+1)` bits), the shadow register, the commit register and the fail counter.

## Test plan
- Reset, then `start`, then beats EF CD AB 89 67 45 23 01 back-to-back, with CRC from the bench model when the check feature is enabled. Required: `key_out`=64'h0123456789ABCDEF and `key_valid`=1 exactly one cycle after the last beat; `s_ready`=0 afterwards.
- Same key, with `s_valid` deasserted for 5 cycles between each beat. Required: identical final `key_out`; `key_out` stays 0 throughout the load.
- `CAS_KEY_CRC_EN`, CRC beat inverted three consecutive times. Required:
  - first two failures go to ERROR, `err`=1, `key_out`=0;
  - third failure goes to LOCKOUT, where `start` has no effect;
  - only `rst` clears the lockout.
- ACTIVE with key 0x0123456789ABCDEF, then `start`. Required: `key_out`=0 and `key_valid`=0 on the next cycle; a reload of key 0xFFFFFFFF00000000 commits correctly.
- `rst` pulsed after 4 accepted beats. Required: all outputs 0; a subsequent full load commits only the new bytes.
- `start` and `s_valid` asserted in the same cycle from IDLE. Required: that beat is not accepted, and beat 0 is taken on the following handshake.
